mac_accumulator_stream: RTL and testbench

Streaming, pipelined successor to the clocked configurable MAC accumulator. Each accepted beat carries VEC_LENGTH signed lanes. The block masks the lanes, reduces them with an adder tree, and folds the sum into a frame accumulator in one of two modes: plain sum, or MSB-first bit-serial shift-accumulate with per-beat negation. Frames are delimited by first/last flags, results leave on a valid/ready port, and optional saturation sets a sticky overflow flag. It sits between the lane multipliers and the output buffer of a PE column.

---
 rtl/mac_accum_pkg.sv | 27 ++
 rtl/mac_adder_tree.sv | 35 +++
 rtl/mac_accumulator_stream.sv | 171 +++++++++++++++++
 tb/tb_mac_accumulator_stream.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mac_accum_pkg.sv
// mac_accum_pkg: shared types and width/limit helpers for the streaming MAC accumulator.
// Rev 1.0
`default_nettype none

package mac_accum_pkg;

   typedef enum logic {
      ACC_SUM   = 1'b0,
      ACC_SHIFT = 1'b1
   } acc_mode_t;

   function automatic int tree_width(input int data_width, input int vec_length);
      return data_width + $clog2(vec_length) + 1;
   endfunction

   // Low acc_width bits hold the signed limits; upper bits are don't-care.
   function automatic logic [127:0] sat_max_f(input int acc_width);
      return (128'd1 << (acc_width - 1)) - 128'd1;
   endfunction

   function automatic logic [127:0] sat_min_f(input int acc_width);
      return ~sat_max_f(acc_width);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_adder_tree.sv
// mac_adder_tree: combinational binary reduction of VEC_LENGTH signed lanes to TW bits.
// Rev 1.0
`default_nettype none

module mac_adder_tree
   import mac_accum_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int VEC_LENGTH = 4,
   parameter int TW         = tree_width(DATA_WIDTH, VEC_LENGTH)
) (
   input  logic signed [DATA_WIDTH-1:0] lanes_i [VEC_LENGTH],
   output logic signed [TW-1:0]         sum_o
);

   localparam int LEVELS = $clog2(VEC_LENGTH);

   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      logic signed [TW-1:0] v [VEC_LENGTH >> l];
      if (l == 0) begin : g_leaf
         for (genvar k = 0; k < VEC_LENGTH; k++) begin : g_lane
            assign v[k] = {{(TW-DATA_WIDTH){lanes_i[k][DATA_WIDTH-1]}}, lanes_i[k]};
         end
      end else begin : g_add
         for (genvar k = 0; k < (VEC_LENGTH >> l); k++) begin : g_node
            assign v[k] = g_lvl[l-1].v[2*k] + g_lvl[l-1].v[2*k+1];
         end
      end
   end

   assign sum_o = g_lvl[LEVELS].v[0];

endmodule

`default_nettype wire

// File: rtl/mac_accumulator_stream.sv
// mac_accumulator_stream: 3-stage mask / reduce / accumulate pipeline with framed valid/ready result.
// Rev 1.0
`default_nettype none

module mac_accumulator_stream
   import mac_accum_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int VEC_LENGTH = 4,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in [VEC_LENGTH],
   input  logic [VEC_LENGTH-1:0]        lane_en,
   input  logic                         first,
   input  logic                         last,
   input  logic                         neg,
   input  logic                         mode,
   input  logic                         sat_en,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_WIDTH-1:0]  out,
   output logic                         ovf
);

   localparam int TW = tree_width(DATA_WIDTH, VEC_LENGTH);
   localparam int XW = ACC_WIDTH + 2;
   localparam logic [127:0] C_MAX_FULL = sat_max_f(ACC_WIDTH);
   localparam logic [127:0] C_MIN_FULL = sat_min_f(ACC_WIDTH);
   localparam logic [ACC_WIDTH-1:0] C_MAX = C_MAX_FULL[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0] C_MIN = C_MIN_FULL[ACC_WIDTH-1:0];

   logic                         s1_valid_q;
   logic signed [DATA_WIDTH-1:0] s1_lanes_q [VEC_LENGTH];
   logic                         s1_first_q, s1_last_q, s1_neg_q, s1_sat_q;
   acc_mode_t                    s1_mode_q;

   logic                         s2_valid_q;
   logic signed [TW-1:0]         s2_term_q;
   logic                         s2_first_q, s2_last_q, s2_sat_q;
   acc_mode_t                    s2_mode_q;

   logic [ACC_WIDTH-1:0]         acc_q, acc_d;
   logic                         in_frame_q;
   acc_mode_t                    frame_mode_q;
   logic                         frame_sat_q;
   logic                         frame_ovf_q, ovf_d;

   logic [ACC_WIDTH-1:0]         out_q;
   logic                         ovf_q, out_valid_q;

   logic                         stall;
   logic                         s3_load;
   logic signed [TW-1:0]         tree_sum;

   // Only a last beat about to overwrite an unconsumed result blocks the pipe.
   assign stall    = out_valid_q && !out_ready && s2_valid_q && s2_last_q;
   assign s3_load  = !stall && s2_valid_q && s2_last_q;
   assign in_ready = !stall;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_neg_q   <= 1'b0;
         s1_sat_q   <= 1'b0;
         s1_mode_q  <= ACC_SUM;
         for (int k = 0; k < VEC_LENGTH; k++) s1_lanes_q[k] <= '0;
      end else if (!stall) begin
         s1_valid_q <= in_valid;
         s1_first_q <= first;
         s1_last_q  <= last;
         s1_neg_q   <= neg;
         s1_sat_q   <= sat_en;
         s1_mode_q  <= acc_mode_t'(mode);
         for (int k = 0; k < VEC_LENGTH; k++) s1_lanes_q[k] <= lane_en[k] ? in[k] : '0;
      end
   end

   mac_adder_tree #(
      .DATA_WIDTH (DATA_WIDTH),
      .VEC_LENGTH (VEC_LENGTH),
      .TW         (TW)
   ) u_tree (
      .lanes_i (s1_lanes_q),
      .sum_o   (tree_sum)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         s2_valid_q <= 1'b0;
         s2_term_q  <= '0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_sat_q   <= 1'b0;
         s2_mode_q  <= ACC_SUM;
      end else if (!stall) begin
         s2_valid_q <= s1_valid_q;
         s2_term_q  <= s1_neg_q ? -tree_sum : tree_sum;
         s2_first_q <= s1_first_q;
         s2_last_q  <= s1_last_q;
         s2_sat_q   <= s1_sat_q;
         s2_mode_q  <= s1_mode_q;
      end
   end

   logic            start;
   acc_mode_t       eff_mode;
   logic            eff_sat;
   logic [XW-1:0]   term_x, acc_x, base_x, raw_x;
   logic            fits, clamp;

   always_comb begin
      start    = s2_first_q || !in_frame_q;
      eff_mode = start ? s2_mode_q : frame_mode_q;
      eff_sat  = start ? s2_sat_q  : frame_sat_q;
      term_x   = {{(XW-TW){s2_term_q[TW-1]}}, s2_term_q};
      acc_x    = {{2{acc_q[ACC_WIDTH-1]}}, acc_q};
      if (start)                    base_x = '0;
      else if (eff_mode == ACC_SHIFT) base_x = {acc_x[XW-2:0], 1'b0};
      else                          base_x = acc_x;
      raw_x    = base_x + term_x;
      // In range iff the two guard bits agree with the ACC_WIDTH sign bit.
      fits     = (raw_x[XW-1:ACC_WIDTH-1] == 3'b000) || (raw_x[XW-1:ACC_WIDTH-1] == 3'b111);
      clamp    = eff_sat && !fits;
      if (clamp) acc_d = raw_x[XW-1] ? C_MIN : C_MAX;
      else       acc_d = raw_x[ACC_WIDTH-1:0];
      ovf_d    = eff_sat && (clamp || (!start && frame_ovf_q));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q        <= '0;
         in_frame_q   <= 1'b0;
         frame_mode_q <= ACC_SUM;
         frame_sat_q  <= 1'b0;
         frame_ovf_q  <= 1'b0;
      end else if (!stall && s2_valid_q) begin
         acc_q        <= acc_d;
         in_frame_q   <= !s2_last_q;
         frame_mode_q <= eff_mode;
         frame_sat_q  <= eff_sat;
         frame_ovf_q  <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (s3_load) begin
         out_q       <= acc_d;
         ovf_q       <= ovf_d;
         out_valid_q <= 1'b1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out       = out_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator_stream.sv
// tb_mac_accumulator_stream: directed self-checking bench for mac_accumulator_stream.
// Rev 1.0
`default_nettype none

module tb_mac_accumulator_stream;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic signed [23:0] in_l [4];
   logic [3:0]         lane_en;
   logic               first, last, neg, mode, sat_en;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] out;
   logic               ovf;

   int total = 0;
   int bad   = 0;
   int hs_count = 0;
   int hs_base;

   always #5 clk = ~clk;

   mac_accumulator_stream #(
      .DATA_WIDTH (24),
      .VEC_LENGTH (4),
      .ACC_WIDTH  (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_l),
      .lane_en   (lane_en),
      .first     (first),
      .last      (last),
      .neg       (neg),
      .mode      (mode),
      .sat_en    (sat_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .ovf       (ovf)
   );

   // Inputs are stable mid-cycle, so this sees exactly the handshakes of the next edge.
   always @(negedge clk) if (out_valid && out_ready) hs_count <= hs_count + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic signed [23:0] l0, l1, l2, l3, input logic [3:0] en,
                       input logic f, la, n, m, s);
      in_l[0] = l0; in_l[1] = l1; in_l[2] = l2; in_l[3] = l3;
      lane_en = en; first = f; last = la; neg = n; mode = m; sat_en = s;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      step();
   endtask

   localparam logic signed [23:0] MAXL = 24'sd8388607;

   initial begin
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      lane_en = 4'h0; first = 1'b0; last = 1'b0; neg = 1'b0; mode = 1'b0; sat_en = 1'b0;
      for (int k = 0; k < 4; k++) in_l[k] = '0;
      step(); step();
      reset = 1'b1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out", out, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);

      // Plain sum: 10 + 40, with latency counted from the accepting edge of the last beat.
      beat(1, 2, 3, 4, 4'hF, 1, 0, 0, 0, 0);
      beat(10, 10, 10, 10, 4'hF, 0, 1, 0, 0, 0);
      check("sum_lat_e0", {31'd0, out_valid}, 32'd0);
      idle();
      check("sum_lat_e1", {31'd0, out_valid}, 32'd0);
      idle();
      check("sum_valid", {31'd0, out_valid}, 32'd1);
      check("sum_out", out, 32'd50);
      check("sum_ovf", {31'd0, ovf}, 32'd0);
      idle();
      check("sum_drop", {31'd0, out_valid}, 32'd0);

      // Shift mode, MSB first with negated MSB: -1, -2, -3; later mode bits must be ignored.
      beat(1, 0, 0, 0, 4'hF, 1, 0, 1, 1, 0);
      beat(0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0);
      beat(1, 0, 0, 0, 4'hF, 0, 1, 0, 0, 0);
      idle(); idle();
      check("shift_valid", {31'd0, out_valid}, 32'd1);
      check("shift_out", out, 32'hFFFF_FFFD);
      idle();

      // Lane mask keeps lanes 0 and 2: 5 + 9.
      beat(5, 7, 9, 11, 4'b0101, 1, 1, 0, 0, 0);
      idle(); idle();
      check("mask_out", out, 32'd14);
      idle();

      // Saturation latched from the first beat only.
      for (int i = 0; i < 64; i++)
         beat(MAXL, MAXL, MAXL, MAXL, 4'hF, i == 0, i == 63, 0, 0, i == 0);
      idle(); idle();
      check("sat64_out", out, 32'd2147483392);
      check("sat64_ovf", {31'd0, ovf}, 32'd0);
      idle();
      for (int i = 0; i < 65; i++)
         beat(MAXL, MAXL, MAXL, MAXL, 4'hF, i == 0, i == 64, 0, 0, i == 0);
      idle(); idle();
      check("sat65_out", out, 32'h7FFF_FFFF);
      check("sat65_ovf", {31'd0, ovf}, 32'd1);
      idle();
      for (int i = 0; i < 65; i++)
         beat(MAXL, MAXL, MAXL, MAXL, 4'hF, i == 0, i == 64, 0, 0, i != 0);
      idle(); idle();
      check("wrap65_out", out, 32'h81FF_FEFC);
      check("wrap65_ovf", {31'd0, ovf}, 32'd0);
      idle();

      // Backpressure: two back-to-back frames (50, 8) while the sink is not ready.
      out_ready = 1'b0;
      hs_base = hs_count;
      beat(1, 2, 3, 4, 4'hF, 1, 0, 0, 0, 0);
      beat(10, 10, 10, 10, 4'hF, 0, 1, 0, 0, 0);
      beat(1, 1, 1, 1, 4'hF, 1, 0, 0, 0, 0);
      beat(1, 1, 1, 1, 4'hF, 0, 1, 0, 0, 0);
      check("bp_out1", out, 32'd50);
      check("bp_ready_flow", {31'd0, in_ready}, 32'd1);
      idle();
      check("bp_ready_drop", {31'd0, in_ready}, 32'd0);
      check("bp_hold1", out, 32'd50);
      idle();
      check("bp_hold2", out, 32'd50);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      check("bp_out2", out, 32'd8);
      check("bp_out2_valid", {31'd0, out_valid}, 32'd1);
      step();
      check("bp_drain", {31'd0, out_valid}, 32'd0);
      check("bp_ready_back", {31'd0, in_ready}, 32'd1);
      check("bp_handshakes", hs_count - hs_base, 32'd2);

      // Reset mid-frame, then a stray non-first last beat must form a fresh frame.
      beat(1, 1, 1, 1, 4'hF, 1, 0, 0, 0, 0);
      beat(1, 1, 1, 1, 4'hF, 0, 0, 0, 0, 0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_out", out, 32'd0);
      check("mrst_ovf", {31'd0, ovf}, 32'd0);
      check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
      beat(2, 2, 2, 2, 4'hF, 0, 1, 0, 0, 0);
      idle(); idle();
      check("mrst_valid", {31'd0, out_valid}, 32'd1);
      check("mrst_result", out, 32'd8);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
